// File: rtl/mdu_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 encodings and FSM states.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

package mdu_iter_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_func;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state;

endpackage

// File: rtl/mdu_iter_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module mdu_divstep
    import mdu_iter_pkg::*;
#(
    parameter int DATA_W = `DATA_SIZE
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              dividend_msb_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem_i < divisor, so a non-negative difference always fits back into DATA_W bits
    always_comb begin
        shifted = {rem_i, dividend_msb_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[DATA_W];
        rem_o   = q_bit_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply and restoring divide on magnitudes.
// Latency: DATA_W+1 cycles from accept to valid_o; divide-by-zero/overflow in 1 cycle.
// Backpressure: single outstanding op; start_i ignored while busy_o, flush_i aborts.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int DATA_W = `DATA_SIZE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        func_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    mdu_state          state;
    mdu_func           func_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic [DATA_W-1:0] opnd;
    logic              neg_q;

    mdu_func           func_in;
    logic              a_sgn;
    logic              b_sgn;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              neg_in;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [DATA_W-1:0] special_res;

    assign func_in = mdu_func'(func_i);
    assign busy_o  = (state != IDLE);

    // Operand decode on the accept cycle
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (func_in)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            MDU_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
        a_neg = a_sgn & op_a_i[DATA_W-1];
        b_neg = b_sgn & op_b_i[DATA_W-1];
        a_mag = a_neg ? (~op_a_i + 1'b1) : op_a_i;
        b_mag = b_neg ? (~op_b_i + 1'b1) : op_b_i;
        // remainder follows the dividend's sign; everything else the product of signs
        neg_in = (func_in == MDU_REM) ? a_neg : (a_neg ^ b_neg);

        div_zero = func_i[2] && (op_b_i == '0);
        div_ovf  = ((func_in == MDU_DIV) || (func_in == MDU_REM)) &&
                   (op_a_i == MOST_NEG) && (op_b_i == ALL_ONES);
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = func_i[1] ? op_a_i : ALL_ONES;
        else
            special_res = func_i[1] ? '0 : op_a_i;
    end

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   div_rem;
    logic                div_q;
    logic [DATA_W-1:0]   hi_nxt;
    logic [DATA_W-1:0]   lo_nxt;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   fin_res;

    mdu_divstep #(
        .DATA_W(DATA_W)
    ) u_divstep (
        .rem_i         (acc_hi),
        .dividend_msb_i(acc_lo[DATA_W-1]),
        .divisor_i     (opnd),
        .rem_o         (div_rem),
        .q_bit_o       (div_q)
    );

    // acc_hi:acc_lo is product (multiply, shifts right) or remainder:quotient (divide, shifts left)
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        if (func_q[2]) begin
            hi_nxt = div_rem;
            lo_nxt = {acc_lo[DATA_W-2:0], div_q};
        end else begin
            hi_nxt = mul_sum[DATA_W:1];
            lo_nxt = {mul_sum[0], acc_lo[DATA_W-1:1]};
        end
        prod = neg_q ? (~{hi_nxt, lo_nxt} + 1'b1) : {hi_nxt, lo_nxt};
        quo  = neg_q ? (~lo_nxt + 1'b1) : lo_nxt;
        rem  = neg_q ? (~hi_nxt + 1'b1) : hi_nxt;
        case (func_q)
            MDU_MUL:                         fin_res = prod[DATA_W-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fin_res = prod[2*DATA_W-1:DATA_W];
            MDU_DIV, MDU_DIVU:               fin_res = quo;
            default:                         fin_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            func_q   <= MDU_MUL;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        func_q <= func_in;
                        neg_q  <= neg_in;
                        cnt    <= CNT_W'(DATA_W - 1);
                        if (special) begin
                            state    <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= special_res;
                        end else begin
                            state  <= CALC;
                            acc_hi <= '0;
                            acc_lo <= func_i[2] ? a_mag : b_mag;
                            opnd   <= func_i[2] ? b_mag : a_mag;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= hi_nxt;
                    acc_lo <= lo_nxt;
                    if (cnt == '0) begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= fin_res;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: result values, strobe timing, flush, and async reset.
module tb_mdu_iter;
    import mdu_iter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  func_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        flush_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    mdu_iter #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .func_i  (func_i),
        .op_a_i  (op_a_i),
        .op_b_i  (op_b_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .result_o(result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Call just after a negedge: that cycle is the accept cycle 0; samples cycles 1..40 on negedges.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int vcyc, output logic [31:0] res, output bit busy_all,
                          output int nvalid);
        start_i = 1'b1; func_i = f; op_a_i = a; op_b_i = b;
        vcyc = -1; res = '0; busy_all = 1'b1; nvalid = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
            if (valid_o) begin
                if (vcyc < 0) begin
                    vcyc = c;
                    res  = result_o;
                end
                nvalid++;
            end
            if ((vcyc < 0 || vcyc == c) && !busy_o) busy_all = 1'b0;
        end
    endtask

    task automatic test_reset;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (result_o !== 32'h0) begin n_errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
    endtask

    task automatic test_mul;
        int v; logic [31:0] r; bit b; int n;
        run_op(MDU_MUL, 32'd7, 32'hFFFFFFFD, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFEB) begin n_errors++; $display("FAIL mul_result: got %h expected ffffffeb", r); end
        n_checks++; if (v != 33) begin n_errors++; $display("FAIL mul_valid_cycle: got %0d expected 33", v); end
        n_checks++; if (!b) begin n_errors++; $display("FAIL mul_busy: got gap in busy_o expected high cycles 1..33"); end
        n_checks++; if (n != 1) begin n_errors++; $display("FAIL mul_valid_count: got %0d expected 1", n); end
    endtask

    task automatic test_mul_high;
        int v; logic [31:0] r; bit b; int n;
        run_op(MDU_MULH, 32'h80000000, 32'h80000000, v, r, b, n);
        n_checks++; if (r !== 32'h40000000 || v != 33) begin n_errors++; $display("FAIL mulh: got %h@%0d expected 40000000@33", r, v); end
        run_op(MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFFE || v != 33) begin n_errors++; $display("FAIL mulhu: got %h@%0d expected fffffffe@33", r, v); end
        run_op(MDU_MULHSU, 32'hFFFFFFFF, 32'd2, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFFF || v != 33) begin n_errors++; $display("FAIL mulhsu: got %h@%0d expected ffffffff@33", r, v); end
    endtask

    task automatic test_div;
        int v; logic [31:0] r; bit b; int n;
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFFD || v != 33) begin n_errors++; $display("FAIL div: got %h@%0d expected fffffffd@33", r, v); end
        run_op(MDU_REM, 32'hFFFFFFF9, 32'd2, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFFF || v != 33) begin n_errors++; $display("FAIL rem: got %h@%0d expected ffffffff@33", r, v); end
        run_op(MDU_DIVU, 32'hFFFFFFF9, 32'd2, v, r, b, n);
        n_checks++; if (r !== 32'h7FFFFFFC || v != 33) begin n_errors++; $display("FAIL divu: got %h@%0d expected 7ffffffc@33", r, v); end
        run_op(MDU_REMU, 32'd1000, 32'd7, v, r, b, n);
        n_checks++; if (r !== 32'd6 || v != 33) begin n_errors++; $display("FAIL remu: got %h@%0d expected 00000006@33", r, v); end
    endtask

    task automatic test_special;
        int v; logic [31:0] r; bit b; int n;
        run_op(MDU_DIV, 32'd5, 32'd0, v, r, b, n);
        n_checks++; if (r !== 32'hFFFFFFFF || v != 1) begin n_errors++; $display("FAIL div_by_zero: got %h@%0d expected ffffffff@1", r, v); end
        n_checks++; if (n != 1) begin n_errors++; $display("FAIL div_by_zero_count: got %0d expected 1", n); end
        run_op(MDU_REMU, 32'd5, 32'd0, v, r, b, n);
        n_checks++; if (r !== 32'd5 || v != 1) begin n_errors++; $display("FAIL remu_by_zero: got %h@%0d expected 00000005@1", r, v); end
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, v, r, b, n);
        n_checks++; if (r !== 32'h80000000 || v != 1) begin n_errors++; $display("FAIL div_overflow: got %h@%0d expected 80000000@1", r, v); end
        run_op(MDU_REM, 32'h80000000, 32'hFFFFFFFF, v, r, b, n);
        n_checks++; if (r !== 32'h0 || v != 1) begin n_errors++; $display("FAIL rem_overflow: got %h@%0d expected 00000000@1", r, v); end
        run_op(MDU_DIVU, 32'h80000000, 32'hFFFFFFFF, v, r, b, n);
        n_checks++; if (r !== 32'h0 || v != 33) begin n_errors++; $display("FAIL divu_no_overflow: got %h@%0d expected 00000000@33", r, v); end
    endtask

    task automatic test_back_to_back;
        int first = -1, second = -1;
        logic [31:0] r1 = '0, r2 = '0, hold = '0;
        start_i = 1'b1; func_i = MDU_MUL; op_a_i = 32'd2; op_b_i = 32'd3;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (valid_o) begin
                if (first < 0) begin first = c; r1 = result_o; end
                else if (second < 0) begin second = c; r2 = result_o; end
            end
            if (c == 33) op_a_i = 32'd5;
            if (c == 40) start_i = 1'b0;
            if (c == 50) hold = result_o;
        end
        n_checks++; if (first != 33 || r1 !== 32'd6) begin n_errors++; $display("FAIL b2b_first: got %h@%0d expected 00000006@33", r1, first); end
        n_checks++; if (second != 67 || r2 !== 32'd15) begin n_errors++; $display("FAIL b2b_second: got %h@%0d expected 0000000f@67", r2, second); end
        n_checks++; if (hold !== 32'd6) begin n_errors++; $display("FAIL result_hold: got %h expected 00000006", hold); end
    endtask

    task automatic test_flush;
        int nv = 0; int v; logic [31:0] r; bit b; int n;
        start_i = 1'b1; func_i = MDU_DIV; op_a_i = 32'd100; op_b_i = 32'd7;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            start_i = (c == 10);
            flush_i = (c == 15);
            if (valid_o) nv++;
            if (c == 16) begin
                n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_idle: got busy %b expected 0", busy_o); end
            end
        end
        n_checks++; if (nv != 0) begin n_errors++; $display("FAIL flush_no_valid: got %0d strobes expected 0", nv); end
        start_i = 1'b1; flush_i = 1'b1; func_i = MDU_MUL;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_over_start: got busy %b expected 0", busy_o); end
        run_op(MDU_MUL, 32'd3, 32'd4, v, r, b, n);
        n_checks++; if (r !== 32'd12 || v != 33) begin n_errors++; $display("FAIL mul_after_flush: got %h@%0d expected 0000000c@33", r, v); end
    endtask

    task automatic test_reset_mid;
        int nv = 0; int v; logic [31:0] r; bit b; int n;
        start_i = 1'b1; func_i = MDU_DIVU; op_a_i = 32'd1000; op_b_i = 32'd10;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start_i = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'h0) begin
            n_errors++; $display("FAIL async_reset: got busy %b valid %b result %h expected 0 0 00000000", busy_o, valid_o, result_o);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (valid_o || busy_o) nv++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (valid_o) nv++;
        end
        n_checks++; if (nv != 0) begin n_errors++; $display("FAIL reset_discard: got %0d active samples expected 0", nv); end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MDU_DIVU, 32'd1000, 32'd10, v, r, b, n);
        n_checks++; if (r !== 32'd100 || v != 33) begin n_errors++; $display("FAIL accept_after_release: got %h@%0d expected 00000064@33", r, v); end
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; func_i = '0; op_a_i = '0; op_b_i = '0; flush_i = 1'b0;
        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_mul();
        test_mul_high();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
